teller_dispatch: RTL and testbench
==================================

TELLER_DISPATCH -- requirements
Module: teller_dispatch

Interface
REQ-001 SHALL have parameter N_TELLERS, default 3, meaning number of teller windows (1..3).
REQ-002 SHALL have parameter SVC_TIME, default 4, meaning nominal service cycles-units per customer.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, meaning cycles to wait for teller acknowledge.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port p_count, input, 3, queue occupancy from the queue counter.
REQ-007 SHALL have port teller_free, input, N_TELLERS, level, bit k high = teller k idle.
REQ-008 SHALL have port call_ack, input, 1, teller confirms the called customer arrived.
REQ-009 SHALL have port call_valid, output, 1, a call is outstanding.
REQ-010 SHALL have port call_id, output, 2, index of the called teller, valid with call_valid.
REQ-011 SHALL have port leave_pulse, output, 1, one-cycle dequeue strobe to the counter's leave input.
REQ-012 SHALL have port no_show, output, 1, one-cycle strobe on call timeout.
REQ-013 SHALL have port wait_time, output, 5, registered estimated wait for a newly arriving customer.

Function
REQ-014 SHALL implement FSM states IDLE, CALL, SETTLE.
REQ-015 IDLE: when p_count != 0 and any teller_free bit is high, SHALL select one teller round-robin, load call_id, assert call_valid, go to CALL next cycle.
REQ-016 IDLE with p_count == 0 or no free teller SHALL stay in IDLE with call_valid low.
REQ-017 Round-robin SHALL start search at (last granted + 1) mod N_TELLERS; after reset the pointer SHALL favour teller 0.
REQ-018 CALL: call_valid and call_id SHALL hold stable until call_ack or timeout.
REQ-019 CALL with call_ack high SHALL assert leave_pulse for exactly one cycle, drop call_valid, go to SETTLE.
REQ-020 CALL timeout counter SHALL reach ACK_TIMEOUT without ack, then SHALL pulse no_show one cycle, drop call_valid, no leave_pulse, go to IDLE.
REQ-021 call_ack and timeout in the same cycle SHALL be treated as ack.
REQ-022 If teller_free[call_id] falls during CALL, the call SHALL continue; freeness is sampled only in IDLE.
REQ-023 SETTLE SHALL last one cycle so the counter's updated p_count is seen before the next decision; SHALL then go to IDLE.
REQ-024 At most one leave_pulse per served customer; no two leave_pulses within 2 cycles.
REQ-025 call_ack outside CALL SHALL be ignored.
REQ-026 wait_time SHALL be SVC_TIME * ceil(p_count / A), A = number of high teller_free bits, updated every cycle with one cycle latency.
REQ-027 wait_time SHALL be 0 when p_count == 0; when A == 0 SHALL be SVC_TIME * p_count; SHALL saturate at 31.

Reset
REQ-028 reset low at a clock edge SHALL force IDLE, call_valid=0, call_id=0, leave_pulse=0, no_show=0, wait_time=0, timeout count 0, RR pointer to teller 0.
REQ-029 reset mid-CALL SHALL abandon the call without leave_pulse or no_show.
REQ-030 reset SHALL dominate all other inputs in the same cycle.

Structure
REQ-031 A shared package sbqm_pkg SHALL hold the FSM state type, N_TELLERS, SVC_TIME, ACK_TIMEOUT defaults and count width 3.
REQ-032 Round-robin selection SHALL be one sub-module rr_arbiter (request vector, pointer in, grant index and grant-valid out).
REQ-033 wait_time division SHALL be combinational small-constant logic, no divider IP.

Verification
REQ-034 p_count=3, teller_free=3'b111, ack 2 cycles after call_valid -> call_id=0, one leave_pulse the cycle ack seen, SETTLE, next call to teller 1.
REQ-035 p_count=0, teller_free=3'b111 for 20 cycles -> call_valid never high, wait_time=0.
REQ-036 p_count=2, teller_free=3'b100, no ack -> call_id=2 held 15 cycles, no_show one cycle, no leave_pulse, new call issued.
REQ-037 p_count=7, teller_free=3'b011 -> wait_time=SVC_TIME*4=16; teller_free=3'b000 -> wait_time=28.
REQ-038 reset low during CALL with ack simultaneously high -> next cycle IDLE, call_valid=0, no leave_pulse.
REQ-039 ack in same cycle timeout expires -> leave_pulse=1, no_show=0.

Source files
------------

// File: rtl/sbqm_pkg.sv
// rtl/sbqm_pkg.sv - shared types, defaults and wait-estimate helper for the teller dispatcher
package sbqm_pkg;
  localparam int N_TELLERS_DEF   = 3;
  localparam int SVC_TIME_DEF    = 4;
  localparam int ACK_TIMEOUT_DEF = 15;
  localparam int CNT_W           = 3;
  localparam int WAIT_W          = 5;
  localparam int WAIT_MAX        = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALL   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // ceil(p / a) for a in 0..3; with no free window every customer counts as a full round
  function automatic int ceil_div_small(input logic [CNT_W-1:0] p, input logic [1:0] a);
    int q;
    case (a)
      2'd2: q = (int'(p) + 1) >> 1;
      2'd3: begin
        case (p)
          3'd0:             q = 0;
          3'd1, 3'd2, 3'd3: q = 1;
          3'd4, 3'd5, 3'd6: q = 2;
          default:          q = 3;
        endcase
      end
      default: q = int'(p);
    endcase
    return q;
  endfunction

  function automatic logic [WAIT_W-1:0] wait_est(input logic [CNT_W-1:0] p,
                                                 input logic [1:0] a, input int svc);
    int prod;
    prod = svc * ceil_div_small(p, a);
    if (prod > WAIT_MAX) return WAIT_W'(WAIT_MAX);
    return WAIT_W'(prod);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of one free teller, search starting at the pointer
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [1:0]   i_ptr,
  output logic [1:0]   o_gnt_idx,
  output logic         o_gnt_valid
);
  logic [2:0] w_k;

  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_k         = '0;
    for (int i = 0; i < N; i++) begin
      w_k = {1'b0, i_ptr} + 3'(i);
      if (w_k >= 3'(N)) w_k = w_k - 3'(N);
      if (!o_gnt_valid && i_req[w_k[1:0]]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_k[1:0];
      end
    end
  end
endmodule

// File: rtl/teller_dispatch.sv
// rtl/teller_dispatch.sv - calls queued customers to free teller windows and estimates wait time
module teller_dispatch
  import sbqm_pkg::*;
#(
  parameter int N_TELLERS   = N_TELLERS_DEF,
  parameter int SVC_TIME    = SVC_TIME_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     p_count,
  input  logic [N_TELLERS-1:0] teller_free,
  input  logic                 call_ack,
  output logic                 call_valid,
  output logic [1:0]           call_id,
  output logic                 leave_pulse,
  output logic                 no_show,
  output logic [WAIT_W-1:0]    wait_time
);
  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic              r_call_valid, w_call_valid_nxt;
  logic [1:0]        r_call_id, w_call_id_nxt;
  logic              r_leave, w_leave_nxt;
  logic              r_no_show, w_no_show_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        w_gnt_idx;
  logic              w_gnt_valid;
  logic [1:0]        w_free_cnt;

  rr_arbiter #(.N(N_TELLERS)) u_rr (
    .i_req       (teller_free),
    .i_ptr       (r_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < N_TELLERS; i++) w_free_cnt = w_free_cnt + 2'(teller_free[i]);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_call_valid_nxt = r_call_valid;
    w_call_id_nxt    = r_call_id;
    w_tmo_nxt        = r_tmo;
    w_ptr_nxt        = r_ptr;
    w_leave_nxt      = 1'b0;
    w_no_show_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (p_count != '0 && w_gnt_valid) begin
          w_state_nxt      = ST_CALL;
          w_call_valid_nxt = 1'b1;
          w_call_id_nxt    = w_gnt_idx;
          w_tmo_nxt        = '0;
          w_ptr_nxt        = (w_gnt_idx == 2'(N_TELLERS - 1)) ? 2'd0 : w_gnt_idx + 2'd1;
        end
      end
      ST_CALL: begin
        // ack wins over a timeout expiring in the same cycle
        if (call_ack) begin
          w_state_nxt      = ST_SETTLE;
          w_call_valid_nxt = 1'b0;
          w_leave_nxt      = 1'b1;
          w_tmo_nxt        = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt      = ST_IDLE;
          w_call_valid_nxt = 1'b0;
          w_no_show_nxt    = 1'b1;
          w_tmo_nxt        = '0;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_call_valid <= 1'b0;
      r_call_id    <= '0;
      r_leave      <= 1'b0;
      r_no_show    <= 1'b0;
      r_tmo        <= '0;
      r_ptr        <= '0;
      r_wait       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_call_valid <= w_call_valid_nxt;
      r_call_id    <= w_call_id_nxt;
      r_leave      <= w_leave_nxt;
      r_no_show    <= w_no_show_nxt;
      r_tmo        <= w_tmo_nxt;
      r_ptr        <= w_ptr_nxt;
      r_wait       <= wait_est(p_count, w_free_cnt, SVC_TIME);
    end
  end

  assign call_valid  = r_call_valid;
  assign call_id     = r_call_id;
  assign leave_pulse = r_leave;
  assign no_show     = r_no_show;
  assign wait_time   = r_wait;
endmodule

// File: tb/tb_teller_dispatch.sv
// tb/tb_teller_dispatch.sv - scoreboard bench for teller_dispatch
module tb_teller_dispatch;
  localparam int K_CALL   = 0;
  localparam int K_LEAVE  = 1;
  localparam int K_NOSHOW = 2;

  typedef struct {
    int kind;
    int id;
    int gap;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] p_count;
  logic [2:0] teller_free;
  logic       call_ack;
  logic       call_valid;
  logic [1:0] call_id;
  logic       leave_pulse;
  logic       no_show;
  logic [4:0] wait_time;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  logic prev_cv = 1'b0;
  ev_t exp_q[$];

  teller_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .p_count     (p_count),
    .teller_free (teller_free),
    .call_ack    (call_ack),
    .call_valid  (call_valid),
    .call_id     (call_id),
    .leave_pulse (leave_pulse),
    .no_show     (no_show),
    .wait_time   (wait_time)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int id);
    ev_t e;
    int  gap;
    gap = cyc - last_cyc;
    last_cyc = cyc;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got kind=%0d id=%0d gap=%0d expected nothing", kind, id, gap);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_CALL && e.id != id) || (e.gap >= 0 && e.gap != gap)) begin
        bad++;
        $display("FAIL event: got kind=%0d id=%0d gap=%0d expected kind=%0d id=%0d gap=%0d",
                 kind, id, gap, e.kind, e.id, e.gap);
      end
    end
  endtask

  always @(negedge clk) begin
    if (call_valid && !prev_cv) observe(K_CALL, int'(call_id));
    if (leave_pulse) observe(K_LEAVE, 0);
    if (no_show) observe(K_NOSHOW, 0);
    prev_cv = call_valid;
  end

  task automatic wait_call(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!call_valid && n < 40);
    chk(name, int'(call_valid), 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_check(input string name, input logic [2:0] p, input logic [2:0] f,
                            input int exp);
    p_count = p;
    teller_free = f;
    @(posedge clk);
    @(negedge clk);
    chk(name, int'(wait_time), exp);
  endtask

  initial begin
    int held;
    reset = 1'b0;
    p_count = 3'd0;
    teller_free = 3'b000;
    call_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_call_valid", int'(call_valid), 0);
    chk("rst_call_id", int'(call_id), 0);
    chk("rst_leave", int'(leave_pulse), 0);
    chk("rst_no_show", int'(no_show), 0);
    chk("rst_wait", int'(wait_time), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // empty queue, all windows free, stray ack held high
    teller_free = 3'b111;
    call_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_no_call", int'(call_valid), 0);
    end
    chk("empty_wait", int'(wait_time), 0);
    call_ack = 1'b0;
    @(negedge clk);

    // serve two customers with round-robin advance
    exp_q.push_back('{K_CALL, 0, -1});
    exp_q.push_back('{K_LEAVE, 0, 3});
    exp_q.push_back('{K_CALL, 1, 2});
    exp_q.push_back('{K_LEAVE, 0, 1});
    p_count = 3'd3;
    wait_call("serve1_call");
    chk("serve_wait", int'(wait_time), 4);
    @(posedge clk);
    @(posedge clk);
    #1 call_ack = 1'b1;
    @(posedge clk);
    #1 call_ack = 1'b0;
    p_count = 3'd2;
    wait_call("serve2_call");
    call_ack = 1'b1;
    @(posedge clk);
    #1 call_ack = 1'b0;
    p_count = 3'd0;
    drain("serve_drain");

    // estimates with no window free
    wait_check("wait_7_none", 3'd7, 3'b000, 28);
    wait_check("wait_5_none", 3'd5, 3'b000, 20);
    wait_check("wait_0_none", 3'd0, 3'b000, 0);

    // single free window, nobody answers
    exp_q.push_back('{K_CALL, 2, -1});
    exp_q.push_back('{K_NOSHOW, 0, 15});
    exp_q.push_back('{K_CALL, 2, 1});
    exp_q.push_back('{K_LEAVE, 0, 1});
    p_count = 3'd2;
    teller_free = 3'b100;
    wait_call("noshow_call");
    chk("noshow_wait", int'(wait_time), 8);
    held = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (call_valid && call_id == 2'd2) held++;
    end
    chk("noshow_held", held, 14);
    @(negedge clk);
    chk("noshow_pulse", int'(no_show), 1);
    chk("noshow_no_leave", int'(leave_pulse), 0);
    chk("noshow_drop", int'(call_valid), 0);
    wait_call("noshow_recall");
    call_ack = 1'b1;
    @(posedge clk);
    #1 call_ack = 1'b0;
    p_count = 3'd0;
    drain("noshow_drain");

    // ack on the very cycle the timeout expires, window drops mid-call
    exp_q.push_back('{K_CALL, 0, -1});
    exp_q.push_back('{K_LEAVE, 0, 15});
    p_count = 3'd7;
    teller_free = 3'b011;
    wait_call("late_ack_call");
    chk("wait_7_two", int'(wait_time), 16);
    repeat (5) @(posedge clk);
    #1 teller_free = 3'b010;
    repeat (9) @(posedge clk);
    #1 call_ack = 1'b1;
    @(posedge clk);
    #1 call_ack = 1'b0;
    p_count = 3'd0;
    @(negedge clk);
    chk("late_ack_leave", int'(leave_pulse), 1);
    chk("late_ack_no_noshow", int'(no_show), 0);
    teller_free = 3'b111;
    drain("late_ack_drain");

    // reset with ack during a call
    exp_q.push_back('{K_CALL, 1, -1});
    p_count = 3'd1;
    wait_call("rst_mid_call");
    reset = 1'b0;
    call_ack = 1'b1;
    p_count = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", int'(call_valid), 0);
    chk("rst_mid_leave", int'(leave_pulse), 0);
    chk("rst_mid_noshow", int'(no_show), 0);
    chk("rst_mid_id", int'(call_id), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    call_ack = 1'b0;

    // pointer back at teller 0 after reset
    exp_q.push_back('{K_CALL, 0, -1});
    exp_q.push_back('{K_LEAVE, 0, 1});
    p_count = 3'd1;
    wait_call("post_rst_call");
    call_ack = 1'b1;
    @(posedge clk);
    #1 call_ack = 1'b0;
    p_count = 3'd0;
    drain("post_rst_drain");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
